// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: registers Hsync/Vsync/RGB from the generator,
// verifies line and frame timing, and rebuilds (x, y, rgb) for every active pixel.
module vga_sync_monitor #(
  parameter int CLKS_PER_PIX = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit SYNC_POL     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic [3:0]  vgaRed,
  input  logic [3:0]  vgaGreen,
  input  logic [3:0]  vgaBlue,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [11:0] px_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic        h_err,
  output logic        v_err,
  output logic [7:0]  err_count
);

  localparam int H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LINE_CLKS = H_TOT * CLKS_PER_PIX;
  localparam int CNT_W     = $clog2(LINE_CLKS + 2);
  localparam int PIX_W     = $clog2(H_TOT + 2);
  localparam int LN_W      = $clog2(V_TOT + 2);
  localparam int PH_W      = (CLKS_PER_PIX > 1) ? $clog2(CLKS_PER_PIX) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LINE_C     = CNT_W'(LINE_CLKS);
  localparam logic [CNT_W-1:0] HS_C       = CNT_W'(H_SYNC * CLKS_PER_PIX);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(CLKS_PER_PIX - 1);
  localparam logic [PH_W-1:0]  PH_MID     = PH_W'(CLKS_PER_PIX / 2);
  localparam logic [PIX_W-1:0] PIX_MAX    = {PIX_W{1'b1}};
  localparam logic [PIX_W-1:0] X0_C       = PIX_W'(H_SYNC + H_BP);
  localparam logic [PIX_W-1:0] X1_C       = PIX_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [LN_W-1:0]  LN_MAX     = {LN_W{1'b1}};
  localparam logic [LN_W-1:0]  Y0_C       = LN_W'(V_SYNC + V_BP);
  localparam logic [LN_W-1:0]  Y1_C       = LN_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [LN_W-1:0]  V_LAST_C   = LN_W'(V_TOT - 1);
  localparam logic [LN_W-1:0]  V_SYNC_C   = LN_W'(V_SYNC);

  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_t;

  state_t             state;
  logic               hs_p0, hs_p1, vs_p0, vs_p1;
  logic [11:0]        rgb_p0;
  logic [CNT_W-1:0]   clk_cnt, hlow_cnt;
  logic [PH_W-1:0]    ph_cnt;
  logic [PIX_W-1:0]   pix_cnt;
  logic [LN_W-1:0]    line_cnt, vlow_cnt;
  logic               pend, skip, acq_err;

  logic hs_act, vs_act, hedge, vedge, fs, stuck, h_fail, frame_bad, smp;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // stage p0: edge detection and per-cycle checks on the registered pins
  always_comb begin
    hs_act    = (hs_p0 == SYNC_POL);
    vs_act    = (vs_p0 == SYNC_POL);
    hedge     = hs_act && (hs_p1 != SYNC_POL);
    vedge     = vs_act && (vs_p1 != SYNC_POL);
    fs        = hedge && (pend || vedge);
    stuck     = (clk_cnt == CNT_MAX) && !hedge;
    h_fail    = (hedge && !skip && ((clk_cnt != LINE_C) || (hlow_cnt != HS_C))) || stuck;
    // line_cnt excludes the current edge, so a full frame reads V_TOT-1 here
    frame_bad = fs && ((line_cnt != V_LAST_C) || (vlow_cnt != V_SYNC_C));
    smp       = !hedge && (ph_cnt == PH_MID) && (state == LOCKED) &&
                (pix_cnt >= X0_C) && (pix_cnt < X1_C) &&
                (line_cnt >= Y0_C) && (line_cnt < Y1_C);
  end

  always_ff @(posedge clk) begin
    rgb_p0 <= {vgaRed, vgaGreen, vgaBlue};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      hs_p0      <= ~SYNC_POL;
      hs_p1      <= ~SYNC_POL;
      vs_p0      <= ~SYNC_POL;
      vs_p1      <= ~SYNC_POL;
      clk_cnt    <= '0;
      hlow_cnt   <= '0;
      ph_cnt     <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      vlow_cnt   <= '0;
      pend       <= 1'b0;
      skip       <= 1'b0;
      acq_err    <= 1'b0;
      px_valid   <= 1'b0;
      px_x       <= '0;
      px_y       <= '0;
      px_rgb     <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      h_err      <= 1'b0;
      v_err      <= 1'b0;
      err_count  <= '0;
    end else begin
      hs_p0 <= Hsync;
      vs_p0 <= Vsync;
      hs_p1 <= hs_p0;
      vs_p1 <= vs_p0;

      if (hedge) begin
        clk_cnt  <= CNT_W'(1);
        hlow_cnt <= CNT_W'(1);
        ph_cnt   <= PH_W'(1);
        pix_cnt  <= '0;
        skip     <= (state == HUNT);
      end else begin
        if (clk_cnt != CNT_MAX) clk_cnt <= clk_cnt + 1'b1;
        if (hs_act && (hlow_cnt != CNT_MAX)) hlow_cnt <= hlow_cnt + 1'b1;
        if (ph_cnt == PH_LAST) begin
          ph_cnt <= '0;
          if (pix_cnt != PIX_MAX) pix_cnt <= pix_cnt + 1'b1;
        end else begin
          ph_cnt <= ph_cnt + 1'b1;
        end
      end

      if (fs) begin
        pend     <= 1'b0;
        line_cnt <= '0;
        vlow_cnt <= {{(LN_W-1){1'b0}}, vs_act};
      end else begin
        if (vedge) pend <= 1'b1;
        if (hedge && (line_cnt != LN_MAX)) line_cnt <= line_cnt + 1'b1;
        if (hedge && vs_act && (vlow_cnt != LN_MAX)) vlow_cnt <= vlow_cnt + 1'b1;
      end

      frame_done <= 1'b0;
      h_err      <= 1'b0;
      v_err      <= 1'b0;
      case (state)
        HUNT: begin
          if (fs) begin
            state   <= ACQUIRE;
            acq_err <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (fs) begin
            if (acq_err || h_fail || frame_bad) begin
              acq_err <= 1'b0;
            end else begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else if (h_fail) begin
            acq_err <= 1'b1;
          end
        end
        LOCKED: begin
          if (h_fail || frame_bad) begin
            state     <= ACQUIRE;
            locked    <= 1'b0;
            acq_err   <= 1'b0;
            h_err     <= h_fail;
            v_err     <= frame_bad;
            err_count <= sat_add8(err_count, {1'b0, h_fail} + {1'b0, frame_bad});
          end else if (fs) begin
            frame_done <= 1'b1;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase

      // stage p1: pixel strobe one cycle after the mid-pixel sample
      px_valid <= smp;
      if (smp) begin
        px_x   <= 10'(pix_cnt - X0_C);
        px_y   <= 10'(line_cnt - Y0_C);
        px_rgb <= rgb_p0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a reduced 16x12 timing so whole frames fit
// in a short run; a behavioural generator drives the sync/RGB pins.
module tb_vga_sync_monitor;

  localparam int CPP   = 4;
  localparam int HA    = 16;
  localparam int HF    = 2;
  localparam int HS    = 4;
  localparam int HB    = 3;
  localparam int VA    = 12;
  localparam int VF    = 1;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam bit POL   = 1'b0;
  localparam int LINE  = (HA + HF + HS + HB) * CPP;
  localparam int VT    = VA + VF + VS + VB;
  localparam int FRAME = LINE * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Hsync = 1'b1;
  logic        Vsync = 1'b1;
  logic [3:0]  vgaRed = 4'h0;
  logic [3:0]  vgaGreen = 4'h0;
  logic [3:0]  vgaBlue = 4'h0;
  logic        px_valid;
  logic [9:0]  px_x, px_y;
  logic [11:0] px_rgb;
  logic        locked, frame_done, h_err, v_err;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;

  // generator controls (written by the test sequence only)
  bit gen_en = 1'b0;
  bit hs_stuck = 1'b0;
  int vs_off = 0;
  int long_frame = -1;
  // generator position (written by the generator only); shows what is on the pins
  int gline = VT - 2;
  int gclk = -1;
  int gframe = 0;

  vga_sync_monitor #(
    .CLKS_PER_PIX(CPP), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .reset(reset), .Hsync(Hsync), .Vsync(Vsync),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
    .locked(locked), .frame_done(frame_done), .h_err(h_err), .v_err(v_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    int px, pos, len;
    forever begin
      @(posedge clk);
      #2;
      if (!gen_en) begin
        gline = VT - 2;
        gclk  = -1;
        Hsync = ~POL;
        Vsync = ~POL;
        {vgaRed, vgaGreen, vgaBlue} = 12'h000;
      end else begin
        len = LINE + (((gframe == long_frame) && (gline == 8)) ? 4 : 0);
        gclk++;
        if (gclk >= len) begin
          gclk = 0;
          gline++;
          if (gline == VT) begin
            gline = 0;
            gframe++;
          end
        end
        px    = gclk / CPP;
        Hsync = ((px < HS) && !hs_stuck) ? POL : ~POL;
        pos   = gline * LINE + gclk;
        Vsync = (((pos + vs_off) % FRAME) < VS * LINE) ? POL : ~POL;
        if ((px >= HS + HB) && (px < HS + HB + HA) && (gline >= VS + VB) && (gline < VS + VB + VA)) begin
          vgaRed   = 4'(px - (HS + HB));
          vgaGreen = 4'(gline - (VS + VB));
          vgaBlue  = 4'hA;
        end else begin
          {vgaRed, vgaGreen, vgaBlue} = 12'h000;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    gen_en = 1'b0;
    hs_stuck = 1'b0;
    vs_off = 0;
    long_frame = -1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_lock(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (locked === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_gen(input int f, input int l, input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6 * FRAME; i++) begin
      @(negedge clk);
      if ((f < 0 || gframe == f) && gline == l && gclk == c) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    @(posedge clk);
    #1;
    reset = 1'b1;
    gen_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({px_valid, locked, frame_done, h_err, v_err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, expected 00000", {px_valid, locked, frame_done, h_err, v_err});
    end
    tests++;
    if ({px_x, px_y, px_rgb, err_count} !== 40'h0) begin
      fails++;
      $display("FAIL reset_data: got x=%0d y=%0d rgb=%h cnt=%0d, expected all 0", px_x, px_y, px_rgb, err_count);
    end
    #1 reset = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if ({px_valid, locked, frame_done, h_err, v_err} !== 5'b0 || err_count !== 8'd0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL idle_outputs: got %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_ideal();
    int g0, n, mism, errs;
    bit ok, done;
    logic [9:0] fx, fy, lx, ly;
    logic [11:0] frgb, lrgb;
    do_reset();
    g0 = gframe;
    gen_en = 1'b1;
    wait_gen(g0 + 1, VT - 1, 50, ok);
    tests++;
    if (!ok || locked !== 1'b0) begin
      fails++;
      $display("FAIL lock_not_early: got ok=%0d locked=%b, expected ok=1 locked=0", ok, locked);
    end
    wait_gen(g0 + 2, 0, 20, ok);
    tests++;
    if (!ok || locked !== 1'b1) begin
      fails++;
      $display("FAIL lock_2nd_start: got ok=%0d locked=%b, expected ok=1 locked=1", ok, locked);
    end
    n = 0; mism = 0; errs = 0; done = 1'b0;
    fx = '1; fy = '1; lx = '1; ly = '1; frgb = '1; lrgb = '1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (h_err || v_err) errs++;
      if (px_valid) begin
        if (n == 0) begin fx = px_x; fy = px_y; frgb = px_rgb; end
        lx = px_x; ly = px_y; lrgb = px_rgb;
        if (px_rgb !== {px_x[3:0], px_y[3:0], 4'hA}) mism++;
        n++;
      end
      if (frame_done) begin
        done = 1'b1;
        break;
      end
    end
    tests++;
    if (!done || n !== HA * VA) begin
      fails++;
      $display("FAIL frame_px_count: got %0d (done=%0d), expected %0d", n, done, HA * VA);
    end
    tests++;
    if (fx !== 10'd0 || fy !== 10'd0 || frgb !== 12'h00A) begin
      fails++;
      $display("FAIL first_px: got (%0d,%0d) %h, expected (0,0) 00a", fx, fy, frgb);
    end
    tests++;
    if (lx !== 10'(HA - 1) || ly !== 10'(VA - 1) || lrgb !== 12'hFBA) begin
      fails++;
      $display("FAIL last_px: got (%0d,%0d) %h, expected (%0d,%0d) fba", lx, ly, lrgb, HA - 1, VA - 1);
    end
    tests++;
    if (mism !== 0 || errs !== 0) begin
      fails++;
      $display("FAIL px_rgb_consistency: got %0d bad pixels %0d errors, expected 0 0", mism, errs);
    end
  endtask

  task automatic test_long_line();
    int hcnt, vcnt, lockbad, target;
    bit ok, saw_drop;
    do_reset();
    gen_en = 1'b1;
    wait_lock(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL long_initial_lock: got locked=%b, expected 1", locked);
    end
    target = gframe + 1;
    long_frame = target;
    hcnt = 0; vcnt = 0; lockbad = 0; saw_drop = 1'b0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      @(negedge clk);
      if (h_err) begin
        hcnt++;
        if (locked !== 1'b0) lockbad++;
      end
      if (v_err) vcnt++;
      if (locked === 1'b0) saw_drop = 1'b1;
      if (gframe == target + 2 && gline == 1) break;
    end
    tests++;
    if (hcnt !== 1 || vcnt !== 0 || lockbad !== 0 || !saw_drop) begin
      fails++;
      $display("FAIL long_line_err: got h=%0d v=%0d lockbad=%0d drop=%0d, expected 1 0 0 1", hcnt, vcnt, lockbad, saw_drop);
    end
    tests++;
    if (err_count !== 8'd1 || locked !== 1'b1) begin
      fails++;
      $display("FAIL long_line_relock: got cnt=%0d locked=%b, expected cnt=1 locked=1", err_count, locked);
    end
  endtask

  task automatic test_vsync_align(input int off);
    int mism;
    bit ok, got;
    do_reset();
    vs_off = off;
    gen_en = 1'b1;
    wait_lock(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL vs_lock off=%0d: got locked=%b, expected 1", off, locked);
    end
    got = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (px_valid) begin
        got = 1'b1;
        break;
      end
    end
    tests++;
    if (!got || px_x !== 10'd0 || px_y !== 10'd0 || px_rgb !== 12'h00A || gline != VS + VB) begin
      fails++;
      $display("FAIL vs_line0 off=%0d: got (%0d,%0d) %h at gen line %0d, expected (0,0) 00a at line %0d", off, px_x, px_y, px_rgb, gline, VS + VB);
    end
    mism = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (px_valid && px_rgb !== {px_x[3:0], px_y[3:0], 4'hA}) mism++;
      if (frame_done) break;
    end
    tests++;
    if (mism !== 0) begin
      fails++;
      $display("FAIL vs_rows off=%0d: got %0d misaligned pixels, expected 0", off, mism);
    end
  endtask

  task automatic test_stuck();
    int hcnt, vcnt, lockbad, first;
    bit ok;
    do_reset();
    gen_en = 1'b1;
    wait_lock(ok);
    wait_gen(-1, 8, 50, ok);
    hs_stuck = 1'b1;
    hcnt = 0; vcnt = 0; lockbad = 0; first = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (h_err) begin
        hcnt++;
        if (first < 0) first = i;
        if (locked !== 1'b0) lockbad++;
      end
      if (v_err) vcnt++;
    end
    tests++;
    if (hcnt !== 1 || vcnt !== 0 || lockbad !== 0) begin
      fails++;
      $display("FAIL stuck_err: got h=%0d v=%0d lockbad=%0d, expected 1 0 0", hcnt, vcnt, lockbad);
    end
    tests++;
    if (first < 70 || first > 90) begin
      fails++;
      $display("FAIL stuck_timing: got h_err at cycle %0d, expected 70..90", first);
    end
    tests++;
    if (locked !== 1'b0 || err_count !== 8'd1) begin
      fails++;
      $display("FAIL stuck_state: got locked=%b cnt=%0d, expected 0 1", locked, err_count);
    end
  endtask

  task automatic test_reset_mid();
    int f0, pxc;
    bit ok, done;
    logic lk1;
    do_reset();
    gen_en = 1'b1;
    wait_lock(ok);
    wait_gen(-1, 10, 40, ok);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({px_valid, locked, frame_done, h_err, v_err} !== 5'b0 || {px_x, px_y, px_rgb, err_count} !== 40'h0) begin
      fails++;
      $display("FAIL midreset_outputs: got flags=%b x=%0d y=%0d rgb=%h, expected all 0", {px_valid, locked, frame_done, h_err, v_err}, px_x, px_y, px_rgb);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    f0 = gframe;
    pxc = 0; lk1 = 1'bx; done = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (px_valid) pxc++;
      if (gframe == f0 + 1 && gline == VT - 1 && gclk == 50) lk1 = locked;
      if (gframe == f0 + 2 && gline == 0 && gclk == 20) begin
        done = 1'b1;
        break;
      end
    end
    tests++;
    if (!done || lk1 !== 1'b0 || pxc !== 0) begin
      fails++;
      $display("FAIL midreset_hold: got done=%0d locked_before=%b px=%0d, expected 1 0 0", done, lk1, pxc);
    end
    tests++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL midreset_relock: got locked=%b, expected 1", locked);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_long_line();
    test_vsync_align(0);
    test_vsync_align(20);
    test_stuck();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
